reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//  In-order retirement queue between issue and the architectural regfile.
//  Issue allocates a tail entry and tags the destination register with the returned
//  ROB id; execution units write results back by ROB id.
//  The head retires one entry per cycle, driving the regfile write (value, clear busy)
//  or a pipeline flush on a mispredicted branch.
//  Dispatch queries operand readiness by ROB id.
// PARAMETERS
//  ROB_WIDTH_BIT  3   log2 of entry count (DEPTH = 2**ROB_WIDTH_BIT = 8)
//  REG_ID_BIT     5   architectural register index width
// PORTS
//  clk_in          in   1    clock, all state on posedge
//  rst_in          in   1    synchronous reset, ACTIVE-LOW
//  rdy_in          in   1    0 = pause: all state and outputs frozen, pulses forced 0
//  issue_valid     in   1    allocate request
//  issue_ready     out  1    1 when count != DEPTH (combinational from registered count)
//  issue_has_rd    in   1    entry writes a register
//  issue_rd        in   REG_ID_BIT  destination register
//  issue_is_br     in   1    entry is a branch
//  issue_alt_pc    in   32   redirect PC if branch turns out mispredicted
//  issue_rob_id    out  ROB_WIDTH_BIT  id the entry gets (= tail pointer, combinational)
//  wb_valid        in   1    result writeback
//  wb_rob_id       in   ROB_WIDTH_BIT  target entry
//  wb_value        in   32   result value
//  wb_mispred      in   1    branch resolved opposite to prediction
//  qry{1,2}_id     in   ROB_WIDTH_BIT  operand tag lookup
//  qry{1,2}_ready  out  1    tagged value available (combinational)
//  qry{1,2}_value  out  32   the value; 0 when not ready
//  commit_valid    out  1    one-cycle pulse: head entry retired
//  commit_wr       out  1    retired entry writes commit_rd
//  commit_rd       out  REG_ID_BIT  register to write
//  commit_value    out  32   value to write
//  commit_rob_id   out  ROB_WIDTH_BIT  id retired (regfile clears busy only if tag matches)
//  flush_out       out  1    one-cycle pulse: squash all in-flight state
//  flush_pc        out  32   fetch redirect target, valid with flush_out
//  count_out       out  ROB_WIDTH_BIT+1  occupied entries
// BEHAVIOUR
//  - Reset (rst_in==0 at posedge): head=tail=count=0, all entry busy/ready=0.
//    All registered outputs 0; rst_in dominates rdy_in.
//  - Entry fields: busy, ready, has_rd, rd, is_br, mispred, alt_pc, value.
//  - Issue: on issue_valid && issue_ready && rdy_in, write the entry at tail (busy=1, ready=0).
//    Advance tail modulo DEPTH; count+1.
//  - Writeback: on wb_valid, a busy target entry gets value, mispred and ready=1.
//    A writeback to a non-busy entry is ignored.
//  - Commit eligibility, registered head entry only: count!=0 && busy[head] && ready[head].
//    A writeback lands no earlier than the next cycle's eligibility (min 1-cycle WB->commit).
//  - Commit (non-branch, or branch with mispred=0): next cycle commit_valid=1, fields from head.
//    Clear busy[head], advance head mod DEPTH, count-1.
//    commit_wr equals has_rd; for branches commit_rd and commit_value are 0.
//  - Commit of a mispredicted branch:
//    - Pulse commit_valid (wr=0) and flush_out, with flush_pc=alt_pc.
//    - Clear all busy/ready; head=tail=count=0.
//    - Issue and writeback in that same cycle are discarded.
//  - Simultaneous issue+commit: count unchanged. When full, issue_ready=0 even if a commit
//    frees a slot that cycle.
//  - Pointer wrap: tail/head wrap DEPTH-1 -> 0; full vs empty resolved by count, never pointers.
//  - Query: ready = (busy && ready) of the entry, OR (wb_valid && wb_rob_id==qry_id && entry busy).
//    The bypass takes wb_value.
//  - Pause (rdy_in==0): no allocation, writeback, commit or pointer move.
//    commit_valid/flush_out held 0.
// TESTING
//  1 Reset: rst_in=0 two cycles -> count_out=0, issue_ready=1, issue_rob_id=0.
//    commit_valid=0, flush_out=0.
//  2 Issue rd=5 id0, rd=6 id1; WB id1=0xBB then id0=0xAA.
//    -> commits in order: (rd5, 0xAA, id0) then (rd6, 0xBB, id1), one per cycle.
//  3 Fill 8 entries, no WB -> issue_ready=0 at count 8; a 9th issue_valid is not accepted.
//    WB id0 -> id0 commits; issue_ready=1; next issue gets id0 (wrap).
//  4 Issue ALU id0, branch id1 (alt_pc=0x1000), ALU id2. WB all, branch mispred=1.
//    -> id0 commits; then flush_out=1, flush_pc=0x1000; count_out=0; id2 never commits.
//  5 WB id3=0x55 with qry1_id=3 same cycle -> qry1_ready=1, qry1_value=0x55 (bypass).
//    qry2 on non-ready id -> ready=0, value=0.
//  6 rdy_in=0 during eligible commit and issue_valid -> no commit, count unchanged.
//    rdy_in=1 -> commit next cycle.

Source files
------------

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : reorder_buffer
//  Description : In-order retirement queue. Issue allocates at the tail,
//                execution writes back by ROB id, the head retires one entry
//                per cycle (regfile write or flush on a mispredicted branch),
//                and dispatch looks up operand readiness by ROB id.
//  Revision    : 1.0 - initial release
// ============================================================================
module reorder_buffer #(
    parameter int ROB_WIDTH_BIT = 3,
    parameter int REG_ID_BIT    = 5
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic                     issue_has_rd,
    input  logic [REG_ID_BIT-1:0]    issue_rd,
    input  logic                     issue_is_br,
    input  logic [31:0]              issue_alt_pc,
    output logic [ROB_WIDTH_BIT-1:0] issue_rob_id,
    input  logic                     wb_valid,
    input  logic [ROB_WIDTH_BIT-1:0] wb_rob_id,
    input  logic [31:0]              wb_value,
    input  logic                     wb_mispred,
    input  logic [ROB_WIDTH_BIT-1:0] qry1_id,
    output logic                     qry1_ready,
    output logic [31:0]              qry1_value,
    input  logic [ROB_WIDTH_BIT-1:0] qry2_id,
    output logic                     qry2_ready,
    output logic [31:0]              qry2_value,
    output logic                     commit_valid,
    output logic                     commit_wr,
    output logic [REG_ID_BIT-1:0]    commit_rd,
    output logic [31:0]              commit_value,
    output logic [ROB_WIDTH_BIT-1:0] commit_rob_id,
    output logic                     flush_out,
    output logic [31:0]              flush_pc,
    output logic [ROB_WIDTH_BIT:0]   count_out
);

    localparam int                       DEPTH     = 1 << ROB_WIDTH_BIT;
    localparam logic [ROB_WIDTH_BIT:0]   FULL_CNT  = (ROB_WIDTH_BIT+1)'(DEPTH);
    localparam logic [ROB_WIDTH_BIT:0]   CNT_ONE   = (ROB_WIDTH_BIT+1)'(1);
    localparam logic [ROB_WIDTH_BIT-1:0] PTR_ONE   = (ROB_WIDTH_BIT)'(1);

    // Entry state: control bits as vectors, payload as arrays
    logic [DEPTH-1:0]      ent_busy;
    logic [DEPTH-1:0]      ent_ready;
    logic [DEPTH-1:0]      ent_has_rd;
    logic [DEPTH-1:0]      ent_is_br;
    logic [DEPTH-1:0]      ent_mispred;
    logic [REG_ID_BIT-1:0] ent_rd     [DEPTH];
    logic [31:0]           ent_alt_pc [DEPTH];
    logic [31:0]           ent_value  [DEPTH];

    logic [ROB_WIDTH_BIT-1:0] head;
    logic [ROB_WIDTH_BIT-1:0] tail;
    logic [ROB_WIDTH_BIT:0]   count;

    logic head_eligible;
    logic commit_fire;
    logic flush_fire;
    logic issue_fire;
    logic wb_fire;
    logic qry1_byp;
    logic qry2_byp;
    logic qry1_hit;
    logic qry2_hit;

    // Full/empty is decided by count alone; pointers are equal in both cases
    assign issue_ready   = (count != FULL_CNT);
    assign issue_rob_id  = tail;
    assign count_out     = count;

    assign head_eligible = (count != '0) && ent_busy[head] && ent_ready[head];
    assign commit_fire   = rdy_in && head_eligible;
    assign flush_fire    = commit_fire && ent_is_br[head] && ent_mispred[head];
    // A flushing retirement squashes anything arriving in the same cycle
    assign issue_fire    = rdy_in && issue_valid && issue_ready && !flush_fire;
    assign wb_fire       = rdy_in && wb_valid && ent_busy[wb_rob_id] && !flush_fire;

    // Operand lookup with same-cycle writeback bypass (bypass value is newest)
    assign qry1_byp   = wb_valid && (wb_rob_id == qry1_id) && ent_busy[qry1_id];
    assign qry1_hit   = ent_busy[qry1_id] && ent_ready[qry1_id];
    assign qry1_ready = qry1_hit || qry1_byp;
    assign qry1_value = qry1_byp ? wb_value : (qry1_hit ? ent_value[qry1_id] : 32'd0);

    assign qry2_byp   = wb_valid && (wb_rob_id == qry2_id) && ent_busy[qry2_id];
    assign qry2_hit   = ent_busy[qry2_id] && ent_ready[qry2_id];
    assign qry2_ready = qry2_hit || qry2_byp;
    assign qry2_value = qry2_byp ? wb_value : (qry2_hit ? ent_value[qry2_id] : 32'd0);

    // Head/tail pointers and occupancy count
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_fire) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (issue_fire) begin
                tail <= tail + PTR_ONE;
            end
            if (commit_fire) begin
                head <= head + PTR_ONE;
            end
            case ({issue_fire, commit_fire})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Busy/ready flags; retirement clears last so it wins over a late writeback
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            ent_busy  <= '0;
            ent_ready <= '0;
        end else if (flush_fire) begin
            ent_busy  <= '0;
            ent_ready <= '0;
        end else begin
            if (issue_fire) begin
                ent_busy[tail]  <= 1'b1;
                ent_ready[tail] <= 1'b0;
            end
            if (wb_fire) begin
                ent_ready[wb_rob_id] <= 1'b1;
            end
            if (commit_fire) begin
                ent_busy[head]  <= 1'b0;
                ent_ready[head] <= 1'b0;
            end
        end
    end

    // Entry payload; only meaningful while the entry is busy, so no reset
    always_ff @(posedge clk_in) begin
        if (issue_fire) begin
            ent_has_rd[tail]  <= issue_has_rd;
            ent_rd[tail]      <= issue_rd;
            ent_is_br[tail]   <= issue_is_br;
            ent_alt_pc[tail]  <= issue_alt_pc;
            ent_mispred[tail] <= 1'b0;
        end
        if (wb_fire) begin
            ent_value[wb_rob_id]   <= wb_value;
            ent_mispred[wb_rob_id] <= wb_mispred;
        end
    end

    // Registered retirement and flush outputs; pulses drop while paused
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            commit_valid  <= 1'b0;
            commit_wr     <= 1'b0;
            commit_rd     <= '0;
            commit_value  <= '0;
            commit_rob_id <= '0;
            flush_out     <= 1'b0;
            flush_pc      <= '0;
        end else if (!rdy_in) begin
            commit_valid <= 1'b0;
            flush_out    <= 1'b0;
        end else begin
            commit_valid <= commit_fire;
            flush_out    <= flush_fire;
            if (commit_fire) begin
                commit_rob_id <= head;
                if (flush_fire) begin
                    commit_wr    <= 1'b0;
                    commit_rd    <= '0;
                    commit_value <= '0;
                    flush_pc     <= ent_alt_pc[head];
                end else begin
                    commit_wr    <= ent_has_rd[head];
                    commit_rd    <= ent_is_br[head] ? '0 : ent_rd[head];
                    commit_value <= ent_is_br[head] ? 32'd0 : ent_value[head];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reorder_buffer
//  Description : Directed self-checking bench for reorder_buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        issue_valid;
    logic        issue_ready;
    logic        issue_has_rd;
    logic [4:0]  issue_rd;
    logic        issue_is_br;
    logic [31:0] issue_alt_pc;
    logic [2:0]  issue_rob_id;
    logic        wb_valid;
    logic [2:0]  wb_rob_id;
    logic [31:0] wb_value;
    logic        wb_mispred;
    logic [2:0]  qry1_id;
    logic        qry1_ready;
    logic [31:0] qry1_value;
    logic [2:0]  qry2_id;
    logic        qry2_ready;
    logic [31:0] qry2_value;
    logic        commit_valid;
    logic        commit_wr;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value;
    logic [2:0]  commit_rob_id;
    logic        flush_out;
    logic [31:0] flush_pc;
    logic [3:0]  count_out;

    int n_checks = 0;
    int n_fail   = 0;

    reorder_buffer #(.ROB_WIDTH_BIT(3), .REG_ID_BIT(5)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_has_rd(issue_has_rd), .issue_rd(issue_rd),
        .issue_is_br(issue_is_br), .issue_alt_pc(issue_alt_pc),
        .issue_rob_id(issue_rob_id),
        .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
        .wb_mispred(wb_mispred),
        .qry1_id(qry1_id), .qry1_ready(qry1_ready), .qry1_value(qry1_value),
        .qry2_id(qry2_id), .qry2_ready(qry2_ready), .qry2_value(qry2_value),
        .commit_valid(commit_valid), .commit_wr(commit_wr), .commit_rd(commit_rd),
        .commit_value(commit_value), .commit_rob_id(commit_rob_id),
        .flush_out(flush_out), .flush_pc(flush_pc), .count_out(count_out)
    );

    always #5 clk_in = ~clk_in;

    // Global safety net so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        tick();
        tick();
        rst_in = 1'b1;
    endtask

    // Present one issue, confirm the id it will get, and clock it in
    task automatic issue_op(input logic has_rd, input logic [4:0] rd, input logic is_br,
                            input logic [31:0] alt_pc, input logic [2:0] exp_id);
        issue_valid  = 1'b1;
        issue_has_rd = has_rd;
        issue_rd     = rd;
        issue_is_br  = is_br;
        issue_alt_pc = alt_pc;
        #1;
        check("issue_rob_id", 64'(issue_rob_id), 64'(exp_id));
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic wb_op(input logic [2:0] id, input logic [31:0] val, input logic mis);
        wb_valid   = 1'b1;
        wb_rob_id  = id;
        wb_value   = val;
        wb_mispred = mis;
        tick();
        wb_valid   = 1'b0;
    endtask

    initial begin
        rdy_in = 1'b1; issue_valid = 0; issue_has_rd = 0; issue_rd = 0; issue_is_br = 0;
        issue_alt_pc = 0; wb_valid = 0; wb_rob_id = 0; wb_value = 0; wb_mispred = 0;
        qry1_id = 0; qry2_id = 0;

        // 1: reset state
        do_reset();
        check("rst_count", 64'(count_out), 64'd0);
        check("rst_issue_ready", 64'(issue_ready), 64'd1);
        check("rst_issue_id", 64'(issue_rob_id), 64'd0);
        check("rst_commit_valid", 64'(commit_valid), 64'd0);
        check("rst_flush", 64'(flush_out), 64'd0);

        // 2: out-of-order writeback, in-order retirement
        issue_op(1'b1, 5'd5, 1'b0, 32'h0, 3'd0);
        issue_op(1'b1, 5'd6, 1'b0, 32'h0, 3'd1);
        check("t2_count2", 64'(count_out), 64'd2);
        wb_op(3'd1, 32'hBB, 1'b0);
        check("t2_no_commit_id1_first", 64'(commit_valid), 64'd0);
        wb_op(3'd0, 32'hAA, 1'b0);
        check("t2_wb_to_commit_latency", 64'(commit_valid), 64'd0);
        tick();
        check("t2_c0_valid", 64'(commit_valid), 64'd1);
        check("t2_c0_wr", 64'(commit_wr), 64'd1);
        check("t2_c0_rd", 64'(commit_rd), 64'd5);
        check("t2_c0_value", 64'(commit_value), 64'hAA);
        check("t2_c0_id", 64'(commit_rob_id), 64'd0);
        tick();
        check("t2_c1_valid", 64'(commit_valid), 64'd1);
        check("t2_c1_rd", 64'(commit_rd), 64'd6);
        check("t2_c1_value", 64'(commit_value), 64'hBB);
        check("t2_c1_id", 64'(commit_rob_id), 64'd1);
        check("t2_count_after1", 64'(count_out), 64'd0);
        tick();
        check("t2_idle", 64'(commit_valid), 64'd0);

        // 3: fill, reject when full, wrap after retirement
        do_reset();
        for (int i = 0; i < 8; i++) begin
            issue_op(1'b1, 5'(i + 1), 1'b0, 32'h0, 3'(i));
        end
        check("t3_full_count", 64'(count_out), 64'd8);
        check("t3_full_ready", 64'(issue_ready), 64'd0);
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        check("t3_ninth_rejected", 64'(count_out), 64'd8);
        wb_op(3'd0, 32'h100, 1'b0);
        tick();
        check("t3_commit_valid", 64'(commit_valid), 64'd1);
        check("t3_commit_id", 64'(commit_rob_id), 64'd0);
        check("t3_commit_value", 64'(commit_value), 64'h100);
        check("t3_count7", 64'(count_out), 64'd7);
        check("t3_ready_again", 64'(issue_ready), 64'd1);
        issue_op(1'b1, 5'd20, 1'b0, 32'h0, 3'd0);
        check("t3_refull", 64'(count_out), 64'd8);

        // 4: mispredicted branch flushes younger entries
        do_reset();
        issue_op(1'b1, 5'd1, 1'b0, 32'h0,    3'd0);
        issue_op(1'b0, 5'd0, 1'b1, 32'h1000, 3'd1);
        issue_op(1'b1, 5'd3, 1'b0, 32'h0,    3'd2);
        wb_op(3'd0, 32'h11, 1'b0);
        wb_op(3'd1, 32'h0, 1'b1);
        check("t4_c0_valid", 64'(commit_valid), 64'd1);
        check("t4_c0_id", 64'(commit_rob_id), 64'd0);
        check("t4_c0_value", 64'(commit_value), 64'h11);
        check("t4_c0_noflush", 64'(flush_out), 64'd0);
        wb_op(3'd2, 32'h33, 1'b0);
        check("t4_flush", 64'(flush_out), 64'd1);
        check("t4_flush_pc", 64'(flush_pc), 64'h1000);
        check("t4_br_commit_valid", 64'(commit_valid), 64'd1);
        check("t4_br_commit_wr", 64'(commit_wr), 64'd0);
        check("t4_br_commit_id", 64'(commit_rob_id), 64'd1);
        check("t4_count0", 64'(count_out), 64'd0);
        check("t4_tail0", 64'(issue_rob_id), 64'd0);
        tick();
        check("t4_flush_pulse", 64'(flush_out), 64'd0);
        for (int i = 0; i < 3; i++) begin
            check("t4_id2_never", 64'(commit_valid), 64'd0);
            tick();
        end

        // 5: operand query with writeback bypass
        do_reset();
        for (int i = 0; i < 4; i++) begin
            issue_op(1'b1, 5'(i + 8), 1'b0, 32'h0, 3'(i));
        end
        qry1_id = 3'd3;
        qry2_id = 3'd2;
        #1;
        check("t5_q1_not_ready", 64'(qry1_ready), 64'd0);
        wb_valid = 1'b1; wb_rob_id = 3'd3; wb_value = 32'h55; wb_mispred = 1'b0;
        #1;
        check("t5_q1_bypass_ready", 64'(qry1_ready), 64'd1);
        check("t5_q1_bypass_value", 64'(qry1_value), 64'h55);
        check("t5_q2_ready", 64'(qry2_ready), 64'd0);
        check("t5_q2_value", 64'(qry2_value), 64'd0);
        tick();
        wb_valid = 1'b0;
        #1;
        check("t5_q1_stored_ready", 64'(qry1_ready), 64'd1);
        check("t5_q1_stored_value", 64'(qry1_value), 64'h55);
        check("t5_no_commit_head_busy", 64'(commit_valid), 64'd0);

        // 6: pause freezes an eligible commit and a pending issue
        do_reset();
        issue_op(1'b1, 5'd9, 1'b0, 32'h0, 3'd0);
        wb_op(3'd0, 32'h77, 1'b0);
        rdy_in = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd10; issue_has_rd = 1'b1; issue_is_br = 1'b0;
        tick();
        check("t6_pause_no_commit", 64'(commit_valid), 64'd0);
        check("t6_pause_count", 64'(count_out), 64'd1);
        tick();
        check("t6_pause_no_commit2", 64'(commit_valid), 64'd0);
        check("t6_pause_tail", 64'(issue_rob_id), 64'd1);
        rdy_in = 1'b1;
        issue_valid = 1'b0;
        tick();
        check("t6_resume_commit", 64'(commit_valid), 64'd1);
        check("t6_resume_value", 64'(commit_value), 64'h77);
        check("t6_resume_rd", 64'(commit_rd), 64'd9);
        check("t6_resume_count", 64'(count_out), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
